blinkt_frame_sched: RTL

Frame scheduler for the Blinkt LED bar. It holds one 32-bit pixel register per LED, written from the serial-Wishbone register side. It emits a complete APA102 frame as an AXI-Stream word sequence into the LED bit-shifter (`sendRegAXIS`): a start word, one word per LED, then an end word. A frame is sent when any pixel changes, on an explicit start request, or on a periodic refresh.

---
 rtl/blinkt_pkg.sv | 31 +++
 rtl/blinkt_refresh_timer.sv | 29 ++
 rtl/blinkt_frame_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/blinkt_pkg.sv
// rtl/blinkt_pkg.sv - shared state type, APA102 framing constants and pixel layout for the Blinkt scheduler
package blinkt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PIXEL = 2'd2,
    END   = 2'd3
  } sched_state_t;

  localparam logic [31:0] BLINKT_START_WORD = 32'h0000_0000;
  localparam logic [31:0] BLINKT_END_WORD   = 32'hFFFF_FFFF;
  localparam logic [2:0]  BLINKT_HDR        = 3'b111;

  localparam int PIX_RED_LSB    = 0;
  localparam int PIX_GREEN_LSB  = 8;
  localparam int PIX_BLUE_LSB   = 16;
  localparam int PIX_BRIGHT_LSB = 24;
  localparam int PIX_BRIGHT_MSB = 28;
  localparam int PIX_W          = PIX_BRIGHT_MSB + 1;

  // APA102 LED word: 3-bit header, 5-bit global brightness, then blue, green, red.
  function automatic logic [31:0] pixel_beat(input logic [PIX_W-1:0] pix);
    return {BLINKT_HDR,
            pix[PIX_BRIGHT_MSB:PIX_BRIGHT_LSB],
            pix[PIX_BLUE_LSB+7:PIX_BLUE_LSB],
            pix[PIX_GREEN_LSB+7:PIX_GREEN_LSB],
            pix[PIX_RED_LSB+7:PIX_RED_LSB]};
  endfunction

endpackage

// File: rtl/blinkt_refresh_timer.sv
// rtl/blinkt_refresh_timer.sv - idle-cycle counter that pulses expire once every CYCLES counted cycles
module blinkt_refresh_timer #(
  parameter int CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expire
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = count_en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/blinkt_frame_sched.sv
// rtl/blinkt_frame_sched.sv - pixel register bank and APA102 frame sequencer feeding the LED shifter stream
module blinkt_frame_sched
  import blinkt_pkg::*;
#(
  parameter int NUM_LEDS       = 8,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_wr_en,
  input  logic [$clog2(NUM_LEDS)-1:0] i_wr_addr,
  input  logic [31:0]                 i_wr_data,
  input  logic                        i_start,
  output logic [31:0]                 m_axis_data,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        o_busy,
  output logic                        o_frame_done
);

  localparam int AW = $clog2(NUM_LEDS);
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_LEDS - 1);
  localparam logic [AW:0]   NUM_LEDS_W = (AW + 1)'(NUM_LEDS);

  logic [PIX_W-1:0] pix    [NUM_LEDS];
  logic [PIX_W-1:0] shadow [NUM_LEDS];

  sched_state_t  state, state_n;
  logic [AW-1:0] idx, idx_n, idx_inc;
  logic          pending;
  logic          snap;
  logic          wr_hit;
  logic          expire;
  logic          hs;
  logic [31:0]   data_n;
  logic          tvalid_n;
  logic          done_n;
  logic          unused_hdr_bits;

  assign unused_hdr_bits = ^i_wr_data[31:PIX_W];
  assign wr_hit          = i_wr_en && ({1'b0, i_wr_addr} < NUM_LEDS_W);
  assign hs              = m_axis_tvalid && m_axis_tready;
  assign idx_inc         = idx + AW'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_LEDS; i++) pix[i] <= '0;
    end else if (wr_hit) begin
      pix[i_wr_addr] <= i_wr_data[PIX_W-1:0];
    end
  end

  // Shadow bank freezes the frame contents so writes during a frame never tear it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_LEDS; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_LEDS; i++) shadow[i] <= pix[i];
    end
  end

  // A new request in the snapshot cycle wins, leaving exactly one follow-up frame queued.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pending <= 1'b1;
    end else if (wr_hit || i_start || expire) begin
      pending <= 1'b1;
    end else if (snap) begin
      pending <= 1'b0;
    end
  end

  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      blinkt_refresh_timer #(
        .CYCLES(REFRESH_CYCLES)
      ) u_refresh_timer (
        .clk      (i_clk),
        .rst      (i_reset),
        .count_en (state == IDLE),
        .clear    (done_n),
        .expire   (expire)
      );
    end else begin : g_no_refresh
      assign expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      idx           <= '0;
      m_axis_data   <= BLINKT_START_WORD;
      m_axis_tvalid <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      m_axis_data   <= data_n;
      m_axis_tvalid <= tvalid_n;
      o_busy        <= (state_n != IDLE);
      o_frame_done  <= done_n;
    end
  end

  // Next word is loaded on the handshake edge, so tvalid stays high across a frame.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    data_n   = m_axis_data;
    tvalid_n = m_axis_tvalid;
    done_n   = 1'b0;
    snap     = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          snap     = 1'b1;
          state_n  = START;
          data_n   = BLINKT_START_WORD;
          tvalid_n = 1'b1;
        end
      end
      START: begin
        if (hs) begin
          state_n = PIXEL;
          idx_n   = '0;
          data_n  = pixel_beat(shadow[0]);
        end
      end
      PIXEL: begin
        if (hs) begin
          if (idx == LAST_IDX) begin
            state_n = END;
            data_n  = BLINKT_END_WORD;
          end else begin
            idx_n  = idx_inc;
            data_n = pixel_beat(shadow[idx_inc]);
          end
        end
      end
      END: begin
        if (hs) begin
          state_n  = IDLE;
          data_n   = BLINKT_START_WORD;
          tvalid_n = 1'b0;
          done_n   = 1'b1;
        end
      end
      default: begin
        state_n  = IDLE;
        tvalid_n = 1'b0;
      end
    endcase
  end

endmodule
